// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared definitions for the multi-channel pulse generator.
//   - command offsets relative to the block's base command code
//   - per-channel state encoding (codes are visible on the register bus)
//   - byte extraction helper for little-endian register reads
package pulse_gen_pkg;

   localparam logic [2:0] OFF_CHSEL = 3'd0;
   localparam logic [2:0] OFF_DELAY = 3'd1;
   localparam logic [2:0] OFF_WIDTH = 3'd2;
   localparam logic [2:0] OFF_COUNT = 3'd3;
   localparam logic [2:0] OFF_GAP   = 3'd4;
   localparam logic [2:0] OFF_CTRL  = 3'd5;
   localparam logic [7:0] NUM_CMDS  = 8'd6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DELAY = 3'd2,
      ST_HIGH  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } ch_state_t;

   // Byte idx of a register holding nbytes bytes; indices past the end read 0.
   function automatic logic [7:0] get_byte(input logic [31:0] value,
                                           input logic [15:0] idx,
                                           input int          nbytes);
      logic [7:0] b;
      b = 8'd0;
      for (int i = 0; i < 4; i++) begin
         b = ((i < nbytes) && (idx == 16'(i))) ? value[8*i +: 8] : b;
      end
      return b;
   endfunction

endpackage

// File: rtl/pulse_channel.sv
// pulse_channel: one output channel of the pulse generator.
// Holds the channel's configuration registers, its state machine and the
// working counters that time delay, pulse width and inter-pulse gap.
// Ports:
//   clkin, reset   clock and synchronous active-high reset
//   trig_edge      one-cycle trigger edge from the shared edge detector
//   wr_en          a byte write addressed to this channel (offsets 1..5)
//   off, idx       command offset and byte index for writes and reads
//   wr_data        write byte
//   rd_data        combinational read byte for (off, idx)
//   pulse, busy    registered channel outputs
module pulse_channel
   import pulse_gen_pkg::*;
#(
   parameter int DELAY_W = 32,
   parameter int WIDTH_W = 16,
   parameter int COUNT_W = 8
) (
   input  logic        clkin,
   input  logic        reset,
   input  logic        trig_edge,
   input  logic        wr_en,
   input  logic [2:0]  off,
   input  logic [15:0] idx,
   input  logic [7:0]  wr_data,
   output logic [7:0]  rd_data,
   output logic        pulse,
   output logic        busy
);

   ch_state_t           state_r, state_s;
   logic [DELAY_W-1:0]  delay_r, gap_r;
   logic [WIDTH_W-1:0]  width_r;
   logic [COUNT_W-1:0]  count_r;
   logic                arm_r, cont_r;
   logic [DELAY_W-1:0]  cnt_r, cnt_s;
   logic [COUNT_W-1:0]  left_r, left_s;
   logic [WIDTH_W-1:0]  run_width_r;   // latched width minus one
   logic [DELAY_W-1:0]  run_gap_r;     // latched gap minus one
   logic [WIDTH_W-1:0]  width_m1_s;
   logic [DELAY_W-1:0]  gap_m1_s;
   logic [COUNT_W-1:0]  count_eff_s;
   logic                ctrl_wr_s, start_s, done_clr_s;
   logic                pulse_r, busy_r;

   assign ctrl_wr_s = wr_en && (off == OFF_CTRL) && (idx == 16'd0);
   assign pulse     = pulse_r;
   assign busy      = busy_r;

   // Zero width/count/gap behave as one; width and gap are kept as (n-1).
   always_comb begin
      width_m1_s  = (width_r == '0) ? '0 : (width_r - WIDTH_W'(1'b1));
      gap_m1_s    = (gap_r == '0) ? '0 : (gap_r - DELAY_W'(1'b1));
      count_eff_s = (count_r == '0) ? COUNT_W'(1'b1) : count_r;
   end

   // Next-state and working-counter logic; an arm=0 write overrides everything.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      left_s     = left_r;
      start_s    = 1'b0;
      done_clr_s = 1'b0;
      if (ctrl_wr_s && !wr_data[0]) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ctrl_wr_s) state_s = ST_ARMED;
               else           state_s = ST_IDLE;
            end
            ST_ARMED: begin
               // An arm write in the same cycle swallows the trigger edge.
               if (ctrl_wr_s) begin
                  state_s = ST_ARMED;
               end else if (trig_edge) begin
                  state_s = ST_DELAY;
                  cnt_s   = delay_r;
                  left_s  = count_eff_s;
                  start_s = 1'b1;
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_DELAY: begin
               if (cnt_r == '0) begin
                  state_s = ST_HIGH;
                  cnt_s   = DELAY_W'(run_width_r);
               end else begin
                  cnt_s = cnt_r - DELAY_W'(1'b1);
               end
            end
            ST_HIGH: begin
               if (cnt_r == '0) begin
                  if (left_r <= COUNT_W'(1'b1)) begin
                     state_s = ST_DONE;
                  end else begin
                     state_s = ST_GAP;
                     left_s  = left_r - COUNT_W'(1'b1);
                     cnt_s   = run_gap_r;
                  end
               end else begin
                  cnt_s = cnt_r - DELAY_W'(1'b1);
               end
            end
            ST_GAP: begin
               if (cnt_r == '0) begin
                  state_s = ST_HIGH;
                  cnt_s   = DELAY_W'(run_width_r);
               end else begin
                  cnt_s = cnt_r - DELAY_W'(1'b1);
               end
            end
            ST_DONE: begin
               if (cont_r) begin
                  state_s = ST_ARMED;
               end else begin
                  state_s    = ST_IDLE;
                  done_clr_s = 1'b1;
               end
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // State, counters, run snapshot and registered outputs.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         left_r      <= '0;
         run_width_r <= '0;
         run_gap_r   <= '0;
         pulse_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         left_r  <= left_s;
         if (start_s) begin
            run_width_r <= width_m1_s;
            run_gap_r   <= gap_m1_s;
         end
         pulse_r <= (state_s == ST_HIGH);
         // Leaving ARMED is the trigger edge itself; busy starts one edge later.
         busy_r  <= (state_r != ST_ARMED) &&
                    (state_s inside {ST_DELAY, ST_HIGH, ST_GAP});
      end
   end

   // Configuration registers, little-endian byte writes.
   always_ff @(posedge clkin) begin
      if (reset) begin
         delay_r <= '0;
         width_r <= WIDTH_W'(1'b1);
         count_r <= COUNT_W'(1'b1);
         gap_r   <= DELAY_W'(1'b1);
         arm_r   <= 1'b0;
         cont_r  <= 1'b0;
      end else begin
         if (wr_en) begin
            for (int i = 0; i < DELAY_W / 8; i++) begin
               if ((off == OFF_DELAY) && (idx == 16'(i))) delay_r[8*i +: 8] <= wr_data;
               if ((off == OFF_GAP)   && (idx == 16'(i))) gap_r[8*i +: 8]   <= wr_data;
            end
            for (int i = 0; i < WIDTH_W / 8; i++) begin
               if ((off == OFF_WIDTH) && (idx == 16'(i))) width_r[8*i +: 8] <= wr_data;
            end
            for (int i = 0; i < COUNT_W / 8; i++) begin
               if ((off == OFF_COUNT) && (idx == 16'(i))) count_r[8*i +: 8] <= wr_data;
            end
         end
         if (ctrl_wr_s) begin
            arm_r  <= wr_data[0];
            cont_r <= wr_data[1];
         end else if (done_clr_s) begin
            arm_r <= 1'b0;
         end
      end
   end

   // Read mux for this channel's registers.
   always_comb begin
      rd_data = 8'd0;
      case (off)
         OFF_DELAY: rd_data = get_byte(32'(delay_r), idx, DELAY_W / 8);
         OFF_WIDTH: rd_data = get_byte(32'(width_r), idx, WIDTH_W / 8);
         OFF_COUNT: rd_data = get_byte(32'(count_r), idx, COUNT_W / 8);
         OFF_GAP:   rd_data = get_byte(32'(gap_r),   idx, DELAY_W / 8);
         OFF_CTRL: begin
            if (idx == 16'd0)      rd_data = {6'd0, cont_r, arm_r};
            else if (idx == 16'd1) rd_data = {5'd0, state_r};
            else                   rd_data = 8'd0;
         end
         default: rd_data = 8'd0;
      endcase
   end

endmodule

// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: NUM_CH independent delayed pulse-train channels
// behind the shared byte-wide register bus.
// Ports:
//   clkin, reset           clock and synchronous active-high reset
//   trigger_in             trigger level; rising edges start armed channels
//   reg_cmd, reg_bytecount command code and byte index of the bus access
//   reg_data_in            write byte
//   reg_read, reg_write    read / write strobes
//   data_read              registered read byte, 0 when not addressed
//   pulse_out, busy        per-channel outputs
module multi_pulse_generator
   import pulse_gen_pkg::*;
#(
   parameter int         NUM_CH   = 2,
   parameter int         DELAY_W  = 32,
   parameter int         WIDTH_W  = 16,
   parameter int         COUNT_W  = 8,
   parameter logic [7:0] CMD_BASE = 8'h20
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              trigger_in,
   input  logic [7:0]        reg_cmd,
   input  logic [15:0]       reg_bytecount,
   input  logic [7:0]        reg_data_in,
   input  logic              reg_read,
   input  logic              reg_write,
   output logic [7:0]        data_read,
   output logic [NUM_CH-1:0] pulse_out,
   output logic [NUM_CH-1:0] busy
);

   logic [7:0]  offset_s;
   logic [2:0]  off_s;
   logic        hit_s;
   logic [7:0]  chsel_r;
   logic        trig_prev_r, trig_edge_s;
   logic [7:0]  rd_byte_s, data_read_r;
   logic [7:0]  ch_rd_s [NUM_CH];
   logic [NUM_CH-1:0] ch_wr_s;

   // Wrapping subtraction makes codes below CMD_BASE miss as well.
   assign offset_s    = reg_cmd - CMD_BASE;
   assign hit_s       = (offset_s < NUM_CMDS);
   assign off_s       = offset_s[2:0];
   assign trig_edge_s = trigger_in && !trig_prev_r;
   assign data_read   = data_read_r;

   // Previous trigger level resets high so a trigger held through reset is not an edge.
   always_ff @(posedge clkin) begin
      if (reset) trig_prev_r <= 1'b1;
      else       trig_prev_r <= trigger_in;
   end

   // Channel select register.
   always_ff @(posedge clkin) begin
      if (reset) begin
         chsel_r <= 8'd0;
      end else if (reg_write && hit_s && (off_s == OFF_CHSEL) && (reg_bytecount == 16'd0)) begin
         chsel_r <= reg_data_in;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // An out-of-range CHSEL matches no channel, so its accesses are no-ops.
      assign ch_wr_s[i] = reg_write && hit_s && (off_s != OFF_CHSEL) && (chsel_r == 8'(i));

      pulse_channel #(
         .DELAY_W (DELAY_W),
         .WIDTH_W (WIDTH_W),
         .COUNT_W (COUNT_W)
      ) u_ch (
         .clkin     (clkin),
         .reset     (reset),
         .trig_edge (trig_edge_s),
         .wr_en     (ch_wr_s[i]),
         .off       (off_s),
         .idx       (reg_bytecount),
         .wr_data   (reg_data_in),
         .rd_data   (ch_rd_s[i]),
         .pulse     (pulse_out[i]),
         .busy      (busy[i])
      );
   end

   // Read mux across CHSEL and the selected channel.
   always_comb begin
      rd_byte_s = 8'd0;
      if (reg_read && hit_s) begin
         if (off_s == OFF_CHSEL) begin
            rd_byte_s = (reg_bytecount == 16'd0) ? chsel_r : 8'd0;
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               rd_byte_s = (chsel_r == 8'(i)) ? ch_rd_s[i] : rd_byte_s;
            end
         end
      end else begin
         rd_byte_s = 8'd0;
      end
   end

   // Registered read data.
   always_ff @(posedge clkin) begin
      if (reset) data_read_r <= 8'd0;
      else       data_read_r <= rd_byte_s;
   end

endmodule

// File: tb/tb_multi_pulse_generator.sv
module tb_multi_pulse_generator;

   localparam logic [7:0] BASE = 8'h20;

   logic        clkin = 1'b0;
   logic        reset = 1'b1;
   logic        trigger_in = 1'b0;
   logic [7:0]  reg_cmd = 8'd0;
   logic [15:0] reg_bytecount = 16'd0;
   logic [7:0]  reg_data_in = 8'd0;
   logic        reg_read = 1'b0;
   logic        reg_write = 1'b0;
   logic [7:0]  data_read;
   logic [1:0]  pulse_out;
   logic [1:0]  busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   multi_pulse_generator #(
      .NUM_CH(2), .DELAY_W(32), .WIDTH_W(16), .COUNT_W(8), .CMD_BASE(BASE)
   ) dut (
      .clkin(clkin), .reset(reset), .trigger_in(trigger_in),
      .reg_cmd(reg_cmd), .reg_bytecount(reg_bytecount), .reg_data_in(reg_data_in),
      .reg_read(reg_read), .reg_write(reg_write), .data_read(data_read),
      .pulse_out(pulse_out), .busy(busy)
   );

   always #5 clkin = ~clkin;
   always @(posedge clkin) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [15:0] idx, input logic [7:0] d);
      @(negedge clkin);
      reg_cmd = BASE + off; reg_bytecount = idx; reg_data_in = d; reg_write = 1'b1;
      @(negedge clkin);
      reg_write = 1'b0;
   endtask

   task automatic rd(input logic [7:0] off, input logic [15:0] idx, output logic [7:0] d);
      @(negedge clkin);
      reg_cmd = BASE + off; reg_bytecount = idx; reg_read = 1'b1;
      @(negedge clkin);
      reg_read = 1'b0;
      d = data_read;
   endtask

   task automatic cfg(input int ch, input logic [31:0] d, input logic [15:0] w,
                      input logic [7:0] c, input logic [31:0] g);
      wr(8'd0, 16'd0, 8'(ch));
      for (int i = 0; i < 4; i++) wr(8'd1, 16'(i), d[8*i +: 8]);
      wr(8'd2, 16'd0, w[7:0]);
      wr(8'd2, 16'd1, w[15:8]);
      wr(8'd3, 16'd0, c);
      for (int i = 0; i < 4; i++) wr(8'd4, 16'(i), g[8*i +: 8]);
   endtask

   task automatic arm(input int ch, input logic a, input logic cont);
      wr(8'd0, 16'd0, 8'(ch));
      wr(8'd5, 16'd0, {6'd0, cont, a});
   endtask

   // Trigger the armed channel, then compare every cycle against the ideal
   // pulse train; a second edge two cycles in must be ignored.
   task automatic fire_check(input string tag, input int ch, input int d, input int w,
                             input int c, input int g);
      int k, s, per, last, we, ce, ge, o;
      logic [1:0] ep, eb;
      we = (w == 0) ? 1 : w;
      ce = (c == 0) ? 1 : c;
      ge = (g == 0) ? 1 : g;
      @(negedge clkin);
      trigger_in = 1'b1;
      @(negedge clkin);
      trigger_in = 1'b0;
      k = cyc;
      s = k + 1 + d;
      per = we + ge;
      last = s + (ce - 1) * per + we - 1;
      for (int t = k + 1; t <= last + 3; t++) begin
         @(negedge clkin);
         ep = 2'b00;
         eb = 2'b00;
         if (t >= s) begin
            o = t - s;
            if ((o / per < ce) && (o % per < we)) ep[ch] = 1'b1;
         end
         if (t <= last) eb[ch] = 1'b1;
         chk($sformatf("%s pulse_out @k+%0d", tag, t - k), pulse_out, ep);
         chk($sformatf("%s busy @k+%0d", tag, t - k), busy, eb);
         if (t == k + 1)      trigger_in = 1'b1;
         else if (t == k + 2) trigger_in = 1'b0;
         else                 trigger_in = trigger_in;
      end
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] d, g;
      logic [15:0] w;
      logic [7:0]  c;
      int ch;

      // Reset state
      repeat (3) @(negedge clkin);
      chk("reset pulse_out", pulse_out, 2'b00);
      chk("reset busy", busy, 2'b00);
      chk("reset data_read", data_read, 8'd0);
      reset = 1'b0;
      rd(8'd0, 16'd0, b); chk("reset CHSEL", b, 8'd0);
      rd(8'd1, 16'd0, b); chk("reset DELAY", b, 8'd0);
      rd(8'd2, 16'd0, b); chk("reset WIDTH", b, 8'd1);
      rd(8'd3, 16'd0, b); chk("reset COUNT", b, 8'd1);
      rd(8'd4, 16'd0, b); chk("reset GAP", b, 8'd1);
      rd(8'd5, 16'd0, b); chk("reset CTRL", b, 8'd0);
      rd(8'd5, 16'd1, b); chk("reset state", b, 8'd0);

      // Single pulse after a delay; one-shot returns to IDLE with arm cleared
      cfg(0, 32'd10, 16'd3, 8'd1, 32'd1);
      arm(0, 1'b1, 1'b0);
      fire_check("single", 0, 10, 3, 1, 1);
      wr(8'd0, 16'd0, 8'd0);
      rd(8'd5, 16'd0, b); chk("single arm readback", b, 8'd0);
      rd(8'd5, 16'd1, b); chk("single state readback", b, 8'd0);

      // Zero delay, three pulses with gaps on channel 1
      cfg(1, 32'd0, 16'd2, 8'd3, 32'd4);
      arm(1, 1'b1, 1'b0);
      fire_check("train", 1, 0, 2, 3, 4);

      // Continuous mode: two identical runs without re-arming
      cfg(0, 32'd5, 16'd3, 8'd2, 32'd2);
      arm(0, 1'b1, 1'b1);
      fire_check("cont run1", 0, 5, 3, 2, 2);
      repeat (20) @(negedge clkin);
      fire_check("cont run2", 0, 5, 3, 2, 2);
      rd(8'd5, 16'd0, b); chk("cont ctrl readback", b, 8'd3);
      rd(8'd5, 16'd1, b); chk("cont state readback", b, 8'd1);
      arm(0, 1'b0, 1'b0);

      // Abort during HIGH
      cfg(0, 32'd2, 16'd10, 8'd1, 32'd1);
      arm(0, 1'b1, 1'b0);
      @(negedge clkin); trigger_in = 1'b1;
      @(negedge clkin); trigger_in = 1'b0;
      repeat (4) @(negedge clkin);
      chk("abort pre pulse", pulse_out, 2'b01);
      wr(8'd5, 16'd0, 8'd0);
      chk("abort pulse_out", pulse_out, 2'b00);
      chk("abort busy", busy, 2'b00);
      rd(8'd5, 16'd1, b); chk("abort state", b, 8'd0);

      // Arm write coinciding with a trigger edge: edge ignored
      @(negedge clkin);
      reg_cmd = BASE + 8'd5; reg_bytecount = 16'd0; reg_data_in = 8'd1;
      reg_write = 1'b1; trigger_in = 1'b1;
      @(negedge clkin);
      reg_write = 1'b0; trigger_in = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clkin);
         chk($sformatf("arm+trig no pulse %0d", i), pulse_out, 2'b00);
      end
      rd(8'd5, 16'd1, b); chk("arm+trig state", b, 8'd1);
      arm(0, 1'b0, 1'b0);

      // Little-endian readback, out-of-range index and CHSEL
      for (int i = 0; i < 4; i++) wr(8'd1, 16'(i), 8'(4 - i));
      for (int i = 0; i < 4; i++) begin
         rd(8'd1, 16'(i), b);
         chk($sformatf("delay byte %0d", i), b, 8'(4 - i));
      end
      rd(8'd1, 16'd4, b); chk("delay byte 4", b, 8'd0);
      @(negedge clkin); chk("idle data_read", data_read, 8'd0);
      wr(8'd0, 16'd0, 8'd7);
      rd(8'd0, 16'd0, b); chk("chsel 7 readback", b, 8'd7);
      wr(8'd1, 16'd0, 8'hAA);
      rd(8'd1, 16'd0, b); chk("chsel 7 delay read", b, 8'd0);
      rd(8'd5, 16'd1, b); chk("chsel 7 state read", b, 8'd0);
      wr(8'd0, 16'd0, 8'd0);
      rd(8'd1, 16'd0, b); chk("chsel 7 write no-op", b, 8'd4);

      // Randomised single-shot runs on either channel
      for (int r = 0; r < 8; r++) begin
         ch = int'($urandom_range(0, 1));
         d  = $urandom_range(0, 20);
         w  = 16'($urandom_range(0, 5));
         c  = 8'($urandom_range(0, 4));
         g  = $urandom_range(0, 5);
         cfg(ch, d, w, c, g);
         arm(ch, 1'b1, 1'b0);
         fire_check($sformatf("rand%0d ch%0d", r, ch), ch, int'(d), int'(w), int'(c), int'(g));
         rd(8'd5, 16'd1, b); chk($sformatf("rand%0d state", r), b, 8'd0);
      end

      // Reset mid-pulse, then trigger held high through reset release
      cfg(0, 32'd0, 16'd20, 8'd1, 32'd1);
      arm(0, 1'b1, 1'b0);
      @(negedge clkin); trigger_in = 1'b1;
      @(negedge clkin); trigger_in = 1'b0;
      repeat (3) @(negedge clkin);
      chk("pre-reset pulse", pulse_out, 2'b01);
      reset = 1'b1; trigger_in = 1'b1;
      @(negedge clkin);
      chk("mid reset pulse_out", pulse_out, 2'b00);
      chk("mid reset busy", busy, 2'b00);
      chk("mid reset data_read", data_read, 8'd0);
      reset = 1'b0;
      arm(0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clkin);
         chk($sformatf("held trigger no pulse %0d", i), pulse_out, 2'b00);
      end
      rd(8'd5, 16'd1, b); chk("held trigger state", b, 8'd1);
      trigger_in = 1'b0;
      fire_check("post-reset defaults", 0, 0, 1, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
